// File: rtl/yangmips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : yangmips_bus_pkg
// Purpose  : Shared definitions for the yangmips bus arbiter: FSM state
//            encoding, default bus widths and the all-bytes-enabled mask.
// Revision : 1.0 - initial release
// ============================================================================
package yangmips_bus_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  // Byte-enable mask for a full-word access at the default data width.
  localparam logic [DEF_DW/8-1:0] SEL_ALL = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage : yangmips_bus_pkg
`default_nettype wire

// File: rtl/yangmips_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : yangmips_bus_watchdog
// Purpose  : Busy-cycle counter used to abort a stuck slave transaction.
//            Counts ticks since the last clear and flags expiry once the
//            count equals TIMEOUT_CYCLES. Saturates at that value.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_clear      - restart the count from zero
//            i_tick       - one busy cycle without slave completion
//            o_expire     - count has reached TIMEOUT_CYCLES
// Revision : 1.0 - initial release
// ============================================================================
module yangmips_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] c_limit = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_tick && (r_count != c_limit)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = (r_count == c_limit);

endmodule : yangmips_bus_watchdog
`default_nettype wire

// File: rtl/yangmips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : yangmips_bus_arbiter
// Purpose  : Shares one memory/bus slave port between the instruction-fetch
//            (I) and data-access (D) requesters of the CPU core, one
//            transaction at a time. Data has priority, except that a pending
//            fetch wins once right after a data transaction.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            i_req/i_addr              - fetch request and address
//            i_rdata/i_ack             - fetch data and completion pulse
//            d_req/d_we/d_sel/d_addr/d_wdata - data request fields
//            d_rdata/d_ack             - data read data and completion pulse
//            m_req/m_we/m_sel/m_addr/m_wdata - registered slave request
//            m_rdata/m_ack             - slave read data and completion
//            stall_o                   - a requester is still waiting
//            err_o                     - transaction aborted by timeout
// Config   : ARB_TIMEOUT_EN - when defined, a transaction busy for
//            TIMEOUT_CYCLES cycles without m_ack is completed with zero
//            data and err_o pulses. Otherwise BUSY waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module yangmips_bus_arbiter
  import yangmips_bus_pkg::*;
#(
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_sel,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_sel,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output logic            stall_o,
  output logic            err_o
);

  arb_state_e      r_state;
  logic            r_last_d;
  logic            r_m_req;
  logic            r_m_we;
  logic [DW/8-1:0] r_m_sel;
  logic [AW-1:0]   r_m_addr;
  logic [DW-1:0]   r_m_wdata;

  logic w_busy;
  logic w_grant_d;
  logic w_grant_i;
  logic w_expire;
  logic w_done;

  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

  // Data wins unless the previous grant was data and a fetch is waiting;
  // this yields strict D/I alternation under contention.
  assign w_grant_d = (r_state == IDLE) && d_req && !(r_last_d && i_req);
  assign w_grant_i = (r_state == IDLE) && !w_grant_d && i_req;

`ifdef ARB_TIMEOUT_EN
  logic w_wd_expire;

  yangmips_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_grant_d | w_grant_i),
    .i_tick   (w_busy & ~m_ack),
    .o_expire (w_wd_expire)
  );

  // A slave completion in the expiry cycle takes precedence over the abort.
  assign w_expire = w_busy & ~m_ack & w_wd_expire;
`else
  assign w_expire = 1'b0;
`endif

  assign w_done = w_busy & (m_ack | w_expire);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_sel   <= '0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state   <= BUSY_D;
            r_last_d  <= 1'b1;
            r_m_req   <= 1'b1;
            r_m_we    <= d_we;
            r_m_sel   <= d_sel;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
          end else if (w_grant_i) begin
            r_state   <= BUSY_I;
            r_last_d  <= 1'b0;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_sel   <= {(DW/8){1'b1}};
            r_m_addr  <= i_addr;
            r_m_wdata <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // Always return through IDLE so every transaction is followed by
          // at least one arbitration cycle.
          if (w_done) begin
            r_state <= IDLE;
            r_m_req <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_m_req <= 1'b0;
        end
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_sel   = r_m_sel;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

  assign i_ack   = (r_state == BUSY_I) && w_done;
  assign d_ack   = (r_state == BUSY_D) && w_done;

  // Read data is forwarded only on a genuine slave completion, so an
  // aborted transaction returns zero.
  assign i_rdata = ((r_state == BUSY_I) && m_ack) ? m_rdata : '0;
  assign d_rdata = ((r_state == BUSY_D) && m_ack) ? m_rdata : '0;

  assign stall_o = (i_req & ~i_ack) | (d_req & ~d_ack);
  assign err_o   = w_expire;

endmodule : yangmips_bus_arbiter
`default_nettype wire
